// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and pixel payload types for the VGA scanout.
package vga_pkg;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_VIS + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_VIS + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned CELL_SHIFT = 3;
  localparam int unsigned FB_COLS    = 80;
  localparam int unsigned FB_ROWS    = 60;
  localparam int unsigned FB_DEPTH   = FB_COLS * FB_ROWS;

  localparam int unsigned HW     = 10;
  localparam int unsigned VW     = 10;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned RGB_W  = 24;
  localparam int unsigned DAC_W  = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // Replicate the top bits so full-scale 8-bit maps to full-scale 10-bit.
  function automatic logic [DAC_W-1:0] exp8to10(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  // row*80 + col, with the multiply folded into two shifts.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 timing: pixel enable at clk/2, h/v counters, stage-0 sync decode and frame strobe.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en_o,
  output logic             vga_clk_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output sync_t            sync_o_c,
  output logic             frame_start_o
);

  logic          pix_en_q, pix_en_d;
  logic          vga_clk_q, vga_clk_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          fs_q, fs_d;

  // Counter advance and frame strobe, both gated by the pixel tick.
  always_comb begin
    pix_en_d  = ~pix_en_q;
    vga_clk_d = pix_en_q;
    h_d       = h_q;
    v_d       = v_q;
    fs_d      = 1'b0;
    if (pix_en_q) begin
      fs_d = (h_q == '0) && (v_q == VW'(V_VIS));
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b1;
      h_q       <= '0;
      v_q       <= '0;
      fs_q      <= 1'b0;
    end else begin
      pix_en_q  <= pix_en_d;
      vga_clk_q <= vga_clk_d;
      h_q       <= h_d;
      v_q       <= v_d;
      fs_q      <= fs_d;
    end
  end

  always_comb begin
    sync_o_c      = SYNC_IDLE;
    sync_o_c.vis  = (h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS));
    sync_o_c.hs_n = !((h_q >= HW'(H_SYNC_START)) && (h_q < HW'(H_SYNC_END)));
    sync_o_c.vs_n = !((v_q >= VW'(V_SYNC_START)) && (v_q < VW'(V_SYNC_END)));
  end

  assign pix_en_o      = pix_en_q;
  assign vga_clk_o     = vga_clk_q;
  assign col_o         = h_q[CELL_SHIFT +: COL_W];
  assign row_o         = v_q[CELL_SHIFT +: ROW_W];
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer read side: issues cell addresses from the raster position and drives the VGA DAC pins.
module vga_fb_scanout
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [RGB_W-1:0]  mem_rdata,
  output logic [DAC_W-1:0]  VGA_R,
  output logic [DAC_W-1:0]  VGA_G,
  output logic [DAC_W-1:0]  VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK,
  output logic              VGA_SYNC,
  output logic              VGA_CLK,
  output logic              frame_start
);

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic             pix_en;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  sync_t            sync0_c;

  vga_timing_gen u_timing (
    .clk           (clk),
    .rst_n         (rst_int_n),
    .pix_en_o      (pix_en),
    .vga_clk_o     (VGA_CLK),
    .col_o         (col),
    .row_o         (row),
    .sync_o_c      (sync0_c),
    .frame_start_o (frame_start)
  );

  rgb24_t            rgb;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  sync_t             sync1_q, sync1_d;
  logic [DAC_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic              hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;

  assign rgb = rgb24_t'(mem_rdata);

  // Stage 1 issues the read; stage 2 picks up rdata one pixel tick later with the delayed syncs.
  always_comb begin
    raddr_d = raddr_q;
    sync1_d = sync1_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    if (pix_en) begin
      if (sync0_c.vis) raddr_d = cell_addr(row, col);
      sync1_d = sync0_c;
      r_d     = sync1_q.vis ? exp8to10(rgb.r) : '0;
      g_d     = sync1_q.vis ? exp8to10(rgb.g) : '0;
      b_d     = sync1_q.vis ? exp8to10(rgb.b) : '0;
      hs_d    = sync1_q.hs_n;
      vs_d    = sync1_q.vs_n;
      blank_d = sync1_q.vis;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      raddr_q <= '0;
      sync1_q <= SYNC_IDLE;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      raddr_q <= raddr_d;
      sync1_q <= sync1_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
    end
  end

  assign mem_raddr = raddr_q;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;
  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign VGA_BLANK = blank_q;
  assign VGA_SYNC  = 1'b0;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: reset values, raster timing, address map, colour path, mid-frame reset.
module tb_vga_fb_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] mem_raddr;
  logic [23:0] mem_rdata = 24'h0;
  logic [9:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank, vga_sync, vga_clk, frame_start;
  logic        ram_colour_mode = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Release goes through a 2-flop synchroniser, then 2 clk per pixel and 2 pixel ticks of pipeline:
  // pins show pixel p (frame-relative) from cycle 2p+6, mem_raddr carries pixel p from cycle 2p+4.
  localparam int FRAME_CLK = 840000;
  localparam int HS_FALL0  = 2 + 2 * 656 + 4;

  vga_fb_scanout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK   (vga_blank),
    .VGA_SYNC    (vga_sync),
    .VGA_CLK     (vga_clk),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram_colour_mode ? 24'hFF0080 : {11'h0, mem_raddr};

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  function automatic int pix_h(input int k);
    return (((k - 6) / 2) % 420000) % 800;
  endfunction

  function automatic int pix_v(input int k);
    return (((k - 6) / 2) % 420000) / 800;
  endfunction

  int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], bl_rise[$], bl_fall[$], fs_rise[$];
  int   fs_high, max_addr, blank_err, hs_err, vs_err, rgb_err, blank_rgb_err, vis_cnt;
  logic hs_p = 1'b1, vs_p = 1'b1, bl_p = 1'b0, fs_p = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
      bl_rise.delete(); bl_fall.delete(); fs_rise.delete();
      fs_high <= 0; max_addr <= 0; blank_err <= 0; hs_err <= 0; vs_err <= 0;
      rgb_err <= 0; blank_rgb_err <= 0; vis_cnt <= 0;
      hs_p <= 1'b1; vs_p <= 1'b1; bl_p <= 1'b0; fs_p <= 1'b0;
    end else begin
      hs_p <= vga_hs; vs_p <= vga_vs; bl_p <= vga_blank; fs_p <= frame_start;
      if (hs_p && !vga_hs) hs_fall.push_back(cyc);
      if (!hs_p && vga_hs) hs_rise.push_back(cyc);
      if (vs_p && !vga_vs) vs_fall.push_back(cyc);
      if (!vs_p && vga_vs) vs_rise.push_back(cyc);
      if (!bl_p && vga_blank) bl_rise.push_back(cyc);
      if (bl_p && !vga_blank) bl_fall.push_back(cyc);
      if (frame_start) fs_high <= fs_high + 1;
      if (frame_start && !fs_p) fs_rise.push_back(cyc);
      if (cyc < FRAME_CLK && int'(mem_raddr) > max_addr) max_addr <= int'(mem_raddr);
      // Second frame: compare every pin sample against the raster model.
      if (cyc >= FRAME_CLK + 6 && cyc < 2 * FRAME_CLK + 6) begin
        if (vga_blank !== ((pix_h(cyc) < 640) && (pix_v(cyc) < 480))) blank_err <= blank_err + 1;
        if (vga_hs !== !((pix_h(cyc) >= 656) && (pix_h(cyc) < 752))) hs_err <= hs_err + 1;
        if (vga_vs !== !((pix_v(cyc) >= 490) && (pix_v(cyc) < 492))) vs_err <= vs_err + 1;
        if (vga_blank) begin
          vis_cnt <= vis_cnt + 1;
          if ({vga_r, vga_g, vga_b} !== {10'h3FF, 10'h000, 10'h202}) rgb_err <= rgb_err + 1;
        end else if ({vga_r, vga_g, vga_b} !== 30'h0) begin
          blank_rgb_err <= blank_rgb_err + 1;
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset_pins(input string pfx);
    check_eq({pfx, "_hs"}, 32'(vga_hs), 32'd1);
    check_eq({pfx, "_vs"}, 32'(vga_vs), 32'd1);
    check_eq({pfx, "_blank"}, 32'(vga_blank), 32'd0);
    check_eq({pfx, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check_eq({pfx, "_raddr"}, 32'(mem_raddr), 32'd0);
    check_eq({pfx, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #60_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_pins("rst");
    check_eq("rst_vga_clk", 32'(vga_clk), 32'd1);
    check_eq("vga_sync", 32'(vga_sync), 32'd0);
    rst_n = 1'b1;

    wait_cyc(38);
    check_eq("raddr_h17_v0", 32'(mem_raddr), 32'd2);
    wait_cyc(101);
    check_eq("vga_clk_odd", 32'(vga_clk), 32'd0);
    wait_cyc(102);
    check_eq("vga_clk_even", 32'(vga_clk), 32'd1);

    wait_cyc(6200);
    check_eq("hs_fall_count", 32'(hs_fall.size() >= 4 && hs_rise.size() >= 3), 32'd1);
    if (hs_fall.size() >= 4 && hs_rise.size() >= 3) begin
      check_eq("hs_first_fall", 32'(hs_fall[0]), 32'(HS_FALL0));
      for (int i = 0; i < 3; i++) begin
        check_eq("hs_period", 32'(hs_fall[i+1] - hs_fall[i]), 32'd1600);
        check_eq("hs_low", 32'(hs_rise[i] - hs_fall[i]), 32'd192);
      end
    end
    check_eq("blank_count", 32'(bl_rise.size() >= 3 && bl_fall.size() >= 3), 32'd1);
    if (bl_rise.size() >= 3 && bl_fall.size() >= 3) begin
      check_eq("blank_first_rise", 32'(bl_rise[0]), 32'd6);
      for (int i = 0; i < 3; i++)
        check_eq("blank_high", 32'(bl_fall[i] - bl_rise[i]), 32'd1280);
    end

    wait_cyc(12820);
    check_eq("raddr_8_8", 32'(mem_raddr), 32'd81);
    wait_cyc(12822);
    check_eq("pin_b_8_8", 32'(vga_b), 32'h145);
    check_eq("pin_g_8_8", 32'(vga_g), 32'h000);
    wait_cyc(767682);
    check_eq("raddr_639_479", 32'(mem_raddr), 32'd4799);
    wait_cyc(767684);
    check_eq("pin_g_639_479", 32'(vga_g), 32'h048);
    check_eq("pin_b_639_479", 32'(vga_b), 32'h2FE);
    wait_cyc(767804);
    check_eq("raddr_hold_blank", 32'(mem_raddr), 32'd4799);

    wait_cyc(780000);
    ram_colour_mode = 1'b1;

    wait_cyc(2 * FRAME_CLK + 10);
    check_eq("raddr_max", 32'(max_addr), 32'd4799);
    check_eq("fs_high_clks", 32'(fs_high), 32'd2);
    check_eq("fs_pulses", 32'(fs_rise.size()), 32'd2);
    if (fs_rise.size() == 2) begin
      check_eq("fs_first", 32'(fs_rise[0]), 32'd768004);
      check_eq("fs_spacing", 32'(fs_rise[1] - fs_rise[0]), 32'(FRAME_CLK));
    end
    check_eq("vs_edges", 32'(vs_fall.size() >= 2 && vs_rise.size() >= 1), 32'd1);
    if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
      check_eq("vs_first_fall", 32'(vs_fall[0]), 32'd784006);
      check_eq("vs_period", 32'(vs_fall[1] - vs_fall[0]), 32'(FRAME_CLK));
      check_eq("vs_low", 32'(vs_rise[0] - vs_fall[0]), 32'd3200);
    end
    check_eq("f1_blank_mism", 32'(blank_err), 32'd0);
    check_eq("f1_hs_mism", 32'(hs_err), 32'd0);
    check_eq("f1_vs_mism", 32'(vs_err), 32'd0);
    check_eq("f1_vis_samples", 32'(vis_cnt), 32'd614400);
    check_eq("f1_vis_rgb_bad", 32'(rgb_err), 32'd0);
    check_eq("f1_blank_rgb_bad", 32'(blank_rgb_err), 32'd0);

    // Third frame, counter state h=300 v=200: pins visible and carrying colour.
    wait_cyc(2 * (2 * 420000 + 200 * 800 + 300) + 2);
    check_eq("mid_pre_blank", 32'(vga_blank), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_pins("mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1400);
    check_eq("mid_hs_fall_seen", 32'(hs_fall.size()), 32'd1);
    if (hs_fall.size() >= 1) check_eq("mid_hs_first_fall", 32'(hs_fall[0]), 32'(HS_FALL0));
    check_eq("mid_blank_seen", 32'(bl_rise.size()), 32'd1);
    if (bl_rise.size() >= 1) check_eq("mid_blank_first_rise", 32'(bl_rise[0]), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
